ncl_fa_sequencer: RTL and testbench



---
 rtl/ncl_pkg.sv | 45 ++++
 rtl/ncl_dr_sync.sv | 33 +++
 rtl/ncl_fa_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_ncl_fa_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncl_pkg.sv
// ncl_pkg
// Shared definitions for the NCL full-adder sequencer.
//   dr_t          : one dual-rail pair, {rail1, rail0}
//   DR_NULL/F/T   : spacer, logic 0 and logic 1 codes (11 is illegal)
//   dr_enc        : single-rail bit -> dual-rail DATA code
//   dr_is_data    : pair holds a valid DATA code
//   dr_is_null    : pair holds the NULL spacer
//   dr_is_illegal : pair has both rails asserted
//   seq_state_t   : sequencer state encoding
package ncl_pkg;

  typedef logic [1:0] dr_t;

  localparam dr_t DR_NULL = 2'b00;
  localparam dr_t DR_F    = 2'b01;
  localparam dr_t DR_T    = 2'b10;
  localparam dr_t DR_ILL  = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    DRV_D,
    WAIT_D,
    DRV_N,
    WAIT_N,
    DONE,
    ERR
  } seq_state_t;

  function automatic dr_t dr_enc(input logic b);
    return b ? DR_T : DR_F;
  endfunction

  function automatic logic dr_is_data(input dr_t d);
    return (d == DR_F) || (d == DR_T);
  endfunction

  function automatic logic dr_is_null(input dr_t d);
    return d == DR_NULL;
  endfunction

  function automatic logic dr_is_illegal(input dr_t d);
    return d == DR_ILL;
  endfunction

endpackage

// File: rtl/ncl_dr_sync.sv
// ncl_dr_sync
// N-bit two-flop synchronizer bringing the asynchronous NCL adder outputs
// into the clk domain. Each bit is synchronized independently; the
// sequencer only trusts a wavefront once every pair agrees, so skew between
// bits only delays completion detection.
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset, clears both flop stages
//   d     : asynchronous input bits
//   q     : synchronized output bits
module ncl_dr_sync #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  logic [N-1:0] meta;

  // First stage may go metastable; the second stage gives it a full cycle
  // to resolve before anything downstream looks at it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ncl_fa_sequencer.sv
// ncl_fa_sequencer
// Bit-serial adder controller that time-shares one dual-rail NCL full adder.
// Operands are accepted over a valid/ready handshake, fed to the adder one
// bit at a time (LSB first) as alternating DATA and NULL wavefronts, and the
// carry is recirculated through a register between bits. A per-phase timer
// and an illegal-code check turn a hung or faulty adder into an err result.
//   clk, rst_n         : clock, asynchronous active-low reset
//   in_valid/in_ready  : operand handshake (in_ready is high only in IDLE)
//   op_a, op_b, c_in   : single-rail operands and carry-in
//   out_valid/out_ready: result handshake
//   sum, c_out, err    : result, final carry, fault flag (valid with out_valid)
//   fa_rst, fa_en      : adder reset (active-high) and enable
//   fa_a, fa_b, fa_cin : registered dual-rail adder inputs
//   fa_s, fa_cout      : asynchronous dual-rail adder outputs
module ncl_fa_sequencer
  import ncl_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             err,
  output logic             fa_rst,
  output logic             fa_en,
  output logic [1:0]       fa_a,
  output logic [1:0]       fa_b,
  output logic [1:0]       fa_cin,
  input  logic [1:0]       fa_s,
  input  logic [1:0]       fa_cout
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(WIDTH - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  seq_state_t     state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [IW-1:0]    bit_idx;
  logic [IW-1:0]    next_idx;
  logic [TW-1:0]    timer;
  logic             err_cnt;
  logic             err_flag;

  logic [3:0] sync_q;
  dr_t        s_sync;
  dr_t        cout_sync;

  logic in_wait;
  logic illegal;
  logic data_done;
  logic null_done;
  logic phase_done;
  logic go_err;

  ncl_dr_sync #(.N(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({fa_cout, fa_s}),
    .q     (sync_q)
  );

  assign s_sync    = sync_q[1:0];
  assign cout_sync = sync_q[3:2];
  assign in_ready  = (state == IDLE);

  // Completion and fault detection on the synchronized adder outputs. A
  // completion on the same edge the timer would expire takes precedence, so
  // the timeout only fires when the current phase is still incomplete.
  always_comb begin
    in_wait    = (state == WAIT_D) || (state == WAIT_N);
    illegal    = dr_is_illegal(s_sync) || dr_is_illegal(cout_sync);
    data_done  = dr_is_data(s_sync) && dr_is_data(cout_sync);
    null_done  = dr_is_null(s_sync) && dr_is_null(cout_sync);
    phase_done = (state == WAIT_D) ? data_done : null_done;
    go_err     = in_wait && (illegal || (!phase_done && (timer == TIMER_LAST)));
    next_idx   = bit_idx + 1'b1;
  end

  // Main sequencer. The adder input rails are loaded on the edge that enters
  // each DRV state, so the wavefront is already on the wires during DRV and
  // the two WAIT cycles cover the synchronizer depth. out_valid and the
  // result registers are loaded on the first DONE cycle, which is why the
  // result appears one cycle after the last NULL completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      carry     <= 1'b0;
      bit_idx   <= '0;
      timer     <= '0;
      err_cnt   <= 1'b0;
      err_flag  <= 1'b0;
      out_valid <= 1'b0;
      sum       <= '0;
      c_out     <= 1'b0;
      err       <= 1'b0;
      fa_en     <= 1'b0;
      fa_rst    <= 1'b1;
      fa_a      <= DR_NULL;
      fa_b      <= DR_NULL;
      fa_cin    <= DR_NULL;
    end else begin
      fa_rst <= 1'b0;
      if (go_err) begin
        state    <= ERR;
        err_cnt  <= 1'b0;
        err_flag <= 1'b1;
        fa_rst   <= 1'b1;
        fa_en    <= 1'b0;
        fa_a     <= DR_NULL;
        fa_b     <= DR_NULL;
        fa_cin   <= DR_NULL;
      end else begin
        unique case (state)
          IDLE: begin
            if (in_valid) begin
              a_reg    <= op_a;
              b_reg    <= op_b;
              carry    <= c_in;
              bit_idx  <= '0;
              acc      <= '0;
              err_flag <= 1'b0;
              fa_a     <= dr_enc(op_a[0]);
              fa_b     <= dr_enc(op_b[0]);
              fa_cin   <= dr_enc(c_in);
              fa_en    <= 1'b1;
              state    <= DRV_D;
            end
          end
          DRV_D: begin
            timer <= '0;
            state <= WAIT_D;
          end
          WAIT_D: begin
            if (data_done) begin
              acc[bit_idx] <= s_sync[1];
              carry        <= cout_sync[1];
              fa_a         <= DR_NULL;
              fa_b         <= DR_NULL;
              fa_cin       <= DR_NULL;
              state        <= DRV_N;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          DRV_N: begin
            timer <= '0;
            state <= WAIT_N;
          end
          WAIT_N: begin
            if (null_done) begin
              if (bit_idx == LAST_IDX) begin
                fa_en <= 1'b0;
                state <= DONE;
              end else begin
                bit_idx <= next_idx;
                fa_a    <= dr_enc(a_reg[next_idx]);
                fa_b    <= dr_enc(b_reg[next_idx]);
                fa_cin  <= dr_enc(carry);
                state   <= DRV_D;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          DONE: begin
            if (!out_valid) begin
              out_valid <= 1'b1;
              sum       <= err_flag ? '0 : acc;
              c_out     <= err_flag ? 1'b0 : carry;
              err       <= err_flag;
            end else if (out_ready) begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
          ERR: begin
            if (!err_cnt) begin
              err_cnt <= 1'b1;
              fa_rst  <= 1'b1;
            end else begin
              state <= DONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ncl_fa_sequencer.sv
// tb_ncl_fa_sequencer
// Self-checking bench for ncl_fa_sequencer. A behavioural NCL full adder
// (1 ns delay, DATA/NULL hysteresis, optional faults) closes the loop. The
// expected result of each transaction comes from plain integer addition and
// the timing rules of the sequencer (cycles per phase, timeout, error
// recovery); a negedge compare process checks the outputs every cycle.
module tb_ncl_fa_sequencer;

  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             err;
  logic             fa_rst;
  logic             fa_en;
  logic [1:0]       fa_a;
  logic [1:0]       fa_b;
  logic [1:0]       fa_cin;
  logic [1:0]       fa_s    = 2'b00;
  logic [1:0]       fa_cout = 2'b00;

  int n_cmp  = 0;
  int n_fail = 0;

  // adder model state and fault controls
  int   adder_wave    = 0;
  logic adder_in_data = 1'b0;
  int   fault         = 0;
  int   fault_wave    = 0;

  // reference model of the current transaction
  logic             model_idle  = 1'b1;
  logic             have_exp    = 1'b0;
  logic [WIDTH-1:0] exp_sum     = '0;
  logic             exp_cout    = 1'b0;
  logic             exp_err     = 1'b0;
  int               exp_lat     = 0;
  int               exp_rst_lat = 0;
  int               lat         = 0;
  int               waves       = 0;
  int               rst_cycles  = 0;
  int               rst_lat     = 0;
  logic             seen_valid  = 1'b0;
  logic             prev_null   = 1'b1;
  int               last_lat    = 0;
  int               last_rst_lat = 0;

  logic [WIDTH-1:0] got_sum;
  logic             got_cout;
  logic             got_err;

  ncl_fa_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .err       (err),
    .fa_rst    (fa_rst),
    .fa_en     (fa_en),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_cin    (fa_cin),
    .fa_s      (fa_s),
    .fa_cout   (fa_cout)
  );

  always #5 clk = ~clk;

  function automatic bit isData(input logic [1:0] d);
    return (d == 2'b01) || (d == 2'b10);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural NCL full adder: outputs go DATA only once all inputs are
  // DATA and return to NULL only once all inputs are NULL.
  always @(fa_a or fa_b or fa_cin or fa_rst) begin
    int tot;
    #1;
    if (fa_rst) begin
      fa_s          = 2'b00;
      fa_cout       = 2'b00;
      adder_in_data = 1'b0;
    end else if (isData(fa_a) && isData(fa_b) && isData(fa_cin)) begin
      if (!adder_in_data) begin
        adder_in_data = 1'b1;
        adder_wave++;
      end
      tot     = int'(fa_a[1]) + int'(fa_b[1]) + int'(fa_cin[1]);
      fa_s    = (tot % 2 == 1) ? 2'b10 : 2'b01;
      fa_cout = (tot >= 2) ? 2'b10 : 2'b01;
      if (fault == 1 && adder_wave == fault_wave) fa_s = 2'b00;
      if (fault == 2) fa_cout = 2'b11;
    end else if (fa_a == 2'b00 && fa_b == 2'b00 && fa_cin == 2'b00) begin
      fa_s          = 2'b00;
      fa_cout       = 2'b00;
      adder_in_data = 1'b0;
    end
  end

  // Compare process: handshake model, wavefront discipline, result and
  // timing checks, evaluated mid-cycle.
  always @(negedge clk) begin
    logic cur_null;
    logic cur_data;
    if (!rst_n) begin
      model_idle = 1'b1;
      have_exp   = 1'b0;
      prev_null  = 1'b1;
    end else begin
      if (!model_idle) lat++;
      cur_null = (fa_a == 2'b00) && (fa_b == 2'b00) && (fa_cin == 2'b00);
      cur_data = isData(fa_a) && isData(fa_b) && isData(fa_cin);
      checkOutput("rail_kind", {31'd0, cur_null || cur_data}, 32'd1);
      if (cur_data && prev_null && !model_idle) waves++;
      prev_null = cur_null;
      if (fa_rst && !model_idle) begin
        if (rst_cycles == 0) rst_lat = lat - 1;
        rst_cycles++;
      end
      checkOutput("in_ready", {31'd0, in_ready}, {31'd0, model_idle});
      if (model_idle) checkOutput("fa_en_idle", {31'd0, fa_en}, 32'd0);
      if (out_valid) begin
        checkOutput("out_valid_expected", {31'd0, have_exp}, 32'd1);
        checkOutput("sum", {24'd0, sum}, {24'd0, exp_sum});
        checkOutput("c_out", {31'd0, c_out}, {31'd0, exp_cout});
        checkOutput("err", {31'd0, err}, {31'd0, exp_err});
        if (!seen_valid) begin
          seen_valid   = 1'b1;
          last_lat     = lat - 1;
          last_rst_lat = rst_lat;
          checkOutput("latency", lat - 1, exp_lat);
          checkOutput("fa_rst_cycles", rst_cycles, exp_err ? 2 : 0);
          if (exp_err) checkOutput("err_entry", rst_lat, exp_rst_lat);
          else         checkOutput("data_waves", waves, WIDTH);
        end
        if (out_ready) begin
          model_idle = 1'b1;
          have_exp   = 1'b0;
        end
      end else if (model_idle && in_valid) begin
        model_idle = 1'b0;
        lat        = 0;
        waves      = 0;
        rst_cycles = 0;
        rst_lat    = 0;
        seen_valid = 1'b0;
      end
    end
  end

  // One full transaction: set the expectation, present operands for one
  // cycle, scramble them, wait for the result, optionally stall with a
  // competing in_valid, then accept.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic ci, input int mode, input int stall);
    logic [WIDTH:0] total;
    total      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    fault      = mode;
    fault_wave = adder_wave + 4;
    if (mode == 0) begin
      exp_sum     = total[WIDTH-1:0];
      exp_cout    = total[WIDTH];
      exp_err     = 1'b0;
      exp_lat     = 6 * WIDTH + 1;
      exp_rst_lat = 0;
    end else begin
      exp_sum     = '0;
      exp_cout    = 1'b0;
      exp_err     = 1'b1;
      exp_rst_lat = (mode == 1) ? (6 * 3 + 1 + TIMEOUT) : 3;
      exp_lat     = exp_rst_lat + 3;
    end
    have_exp = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    c_in     = ci;
    @(posedge clk); #2;
    in_valid = 1'b0;
    op_a     = ~a;
    op_b     = a ^ b;
    c_in     = ~ci;
    for (int k = 0; k < 300 && !out_valid; k++) @(negedge clk);
    checkOutput("result_wait", {31'd0, out_valid}, 32'd1);
    got_sum  = sum;
    got_cout = c_out;
    got_err  = err;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #2;
      in_valid = 1'b1;
      op_a     = b;
      op_b     = a;
    end
    @(posedge clk); #2;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    fault     = 0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    c_in      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_sum", {24'd0, sum}, 32'd0);
    checkOutput("rst_c_out", {31'd0, c_out}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_fa_en", {31'd0, fa_en}, 32'd0);
    checkOutput("rst_rails", {26'd0, fa_a, fa_b, fa_cin}, 32'd0);
    checkOutput("rst_fa_rst", {31'd0, fa_rst}, 32'd1);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("fa_rst_cleared", {31'd0, fa_rst}, 32'd0);

    $display("[TB] basic additions");
    applyStimulus(8'h5A, 8'h3C, 1'b0, 0, 0);
    checkOutput("pin_5A3C_sum", {24'd0, got_sum}, 32'h96);
    checkOutput("pin_5A3C_cout", {31'd0, got_cout}, 32'd0);
    checkOutput("pin_5A3C_err", {31'd0, got_err}, 32'd0);
    checkOutput("pin_latency_49", last_lat, 49);
    applyStimulus(8'hFF, 8'h01, 1'b0, 0, 0);
    checkOutput("pin_FF01_sum", {24'd0, got_sum}, 32'h00);
    checkOutput("pin_FF01_cout", {31'd0, got_cout}, 32'd1);
    applyStimulus(8'hFF, 8'hFF, 1'b1, 0, 0);
    checkOutput("pin_FFFF1_sum", {24'd0, got_sum}, 32'hFF);
    checkOutput("pin_FFFF1_cout", {31'd0, got_cout}, 32'd1);

    $display("[TB] stuck sum on bit 3");
    applyStimulus(8'h12, 8'h34, 1'b0, 1, 0);
    checkOutput("pin_stuck_err", {31'd0, got_err}, 32'd1);
    checkOutput("pin_stuck_sum", {24'd0, got_sum}, 32'd0);
    checkOutput("pin_stuck_entry_34", last_rst_lat, 34);

    $display("[TB] illegal carry code");
    applyStimulus(8'hC3, 8'h5A, 1'b1, 2, 0);
    checkOutput("pin_illegal_err", {31'd0, got_err}, 32'd1);
    applyStimulus(8'h01, 8'h01, 1'b0, 0, 0);
    checkOutput("pin_recover_sum", {24'd0, got_sum}, 32'h02);
    checkOutput("pin_recover_err", {31'd0, got_err}, 32'd0);

    $display("[TB] output stall");
    applyStimulus(8'hA7, 8'h6B, 1'b1, 0, 10);
    checkOutput("pin_stall_sum", {24'd0, got_sum}, 32'h13);
    checkOutput("pin_stall_cout", {31'd0, got_cout}, 32'd1);

    $display("[TB] reset during bit 4");
    have_exp = 1'b0;
    @(posedge clk); #2;
    in_valid = 1'b1;
    op_a     = 8'h77;
    op_b     = 8'h11;
    c_in     = 1'b0;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (26) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid_rst_sum", {24'd0, sum}, 32'd0);
    checkOutput("mid_rst_c_out", {31'd0, c_out}, 32'd0);
    checkOutput("mid_rst_err", {31'd0, err}, 32'd0);
    checkOutput("mid_rst_fa_en", {31'd0, fa_en}, 32'd0);
    checkOutput("mid_rst_rails", {26'd0, fa_a, fa_b, fa_cin}, 32'd0);
    checkOutput("mid_rst_fa_rst", {31'd0, fa_rst}, 32'd1);
    checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("mid_rst_fa_rst_cleared", {31'd0, fa_rst}, 32'd0);
    applyStimulus(8'h10, 8'h20, 1'b0, 0, 0);
    checkOutput("pin_after_rst_sum", {24'd0, got_sum}, 32'h30);
    checkOutput("pin_after_rst_err", {31'd0, got_err}, 32'd0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
